// File: rtl/pe_sched_pkg.sv
// Shared types and default widths for the PE tile scheduler.
package pe_sched_pkg;

  localparam int unsigned IA_TILE_W = 8;
  localparam int unsigned W_TILE_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_LD,
    S_RUN,
    S_DRAIN,
    S_WB,
    S_DONE
  } sched_state_e;

  // A layer is in flight in every state except IDLE and the DONE pulse cycle.
  function automatic logic is_busy(input sched_state_e s);
    return (s != S_IDLE) && (s != S_DONE);
  endfunction

endpackage

// File: rtl/pe_tile_scheduler_if.sv
// Layer-controller, loader, PE and writeback signals of the tile scheduler.
interface pe_tile_scheduler_if #(
  parameter int unsigned IA_TILE_W = pe_sched_pkg::IA_TILE_W,
  parameter int unsigned W_TILE_W  = pe_sched_pkg::W_TILE_W
);

  logic                 i_layer_start;
  logic [IA_TILE_W-1:0] i_num_ia_tiles;
  logic [W_TILE_W-1:0]  i_num_w_tiles;
  logic                 o_busy;
  logic                 o_layer_done;
  logic                 o_fetch_valid;
  logic [IA_TILE_W-1:0] o_fetch_ia_idx;
  logic [W_TILE_W-1:0]  o_fetch_w_idx;
  logic                 i_fetch_ready;
  logic                 i_fetch_done;
  logic                 o_pe_start;
  logic                 i_pe_finish;
  logic                 o_wb_valid;
  logic                 i_wb_ready;

  modport master (
    input  i_layer_start, i_num_ia_tiles, i_num_w_tiles,
    input  i_fetch_ready, i_fetch_done, i_pe_finish, i_wb_ready,
    output o_busy, o_layer_done, o_fetch_valid, o_fetch_ia_idx, o_fetch_w_idx,
    output o_pe_start, o_wb_valid
  );

  modport slave (
    output i_layer_start, i_num_ia_tiles, i_num_w_tiles,
    output i_fetch_ready, i_fetch_done, i_pe_finish, i_wb_ready,
    input  o_busy, o_layer_done, o_fetch_valid, o_fetch_ia_idx, o_fetch_w_idx,
    input  o_pe_start, o_wb_valid
  );

endinterface

// File: rtl/tile_pair_counter.sv
// Nested (ia inner, w outer) tile index counter with latched counts and a last-pair flag.
module tile_pair_counter #(
  parameter int unsigned IA_TILE_W = 8,
  parameter int unsigned W_TILE_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [IA_TILE_W-1:0] num_ia,
  input  logic [W_TILE_W-1:0]  num_w,
  input  logic                 advance,
  output logic [IA_TILE_W-1:0] ia_idx,
  output logic [W_TILE_W-1:0]  w_idx,
  output logic                 last
);

  logic [IA_TILE_W-1:0] num_ia_q;
  logic [W_TILE_W-1:0]  num_w_q;
  logic [IA_TILE_W:0]   ia_inc;
  logic [W_TILE_W:0]    w_inc;
  logic                 ia_wrap;
  logic                 w_last;

  // One extra bit so idx+1 == count compares stay exact at the maximum count.
  assign ia_inc  = {1'b0, ia_idx} + (IA_TILE_W+1)'(1);
  assign w_inc   = {1'b0, w_idx} + (W_TILE_W+1)'(1);
  assign ia_wrap = (ia_inc == {1'b0, num_ia_q});
  assign w_last  = (w_inc == {1'b0, num_w_q});
  assign last    = ia_wrap && w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_ia_q <= '0;
      num_w_q  <= '0;
      ia_idx   <= '0;
      w_idx    <= '0;
    end else if (load) begin
      num_ia_q <= num_ia;
      num_w_q  <= num_w;
      ia_idx   <= '0;
      w_idx    <= '0;
    end else if (advance) begin
      if (ia_wrap) begin
        ia_idx <= '0;
        w_idx  <= w_inc[W_TILE_W-1:0];
      end else begin
        ia_idx <= ia_inc[IA_TILE_W-1:0];
      end
    end
  end

endmodule

// File: rtl/pe_tile_scheduler.sv
// Walks every (W tile, IA tile) pair of a layer: fetch, PE run, drain, writeback.
// Define PE_SCHED_PERF_EN to add busy/stall performance counters.
module pe_tile_scheduler #(
  parameter int unsigned IA_TILE_W = pe_sched_pkg::IA_TILE_W,
  parameter int unsigned W_TILE_W  = pe_sched_pkg::W_TILE_W
`ifdef PE_SCHED_PERF_EN
  , parameter int unsigned PERF_W  = 32
`endif
) (
  input  logic                i_clk,
  input  logic                i_rst,
  pe_tile_scheduler_if.master bus
`ifdef PE_SCHED_PERF_EN
  , output logic [PERF_W-1:0] o_perf_busy_cyc
  , output logic [PERF_W-1:0] o_perf_stall_cyc
`endif
);

  import pe_sched_pkg::*;

  sched_state_e         state;
  sched_state_e         state_next;
  logic                 load;
  logic                 advance;
  logic                 last;
  logic                 zero_layer;
  logic [IA_TILE_W-1:0] ia_idx;
  logic [W_TILE_W-1:0]  w_idx;

  assign zero_layer = (bus.i_num_ia_tiles == '0) || (bus.i_num_w_tiles == '0);

  tile_pair_counter #(
    .IA_TILE_W (IA_TILE_W),
    .W_TILE_W  (W_TILE_W)
  ) u_pair (
    .clk     (i_clk),
    .rst     (i_rst),
    .load    (load),
    .num_ia  (bus.i_num_ia_tiles),
    .num_w   (bus.i_num_w_tiles),
    .advance (advance),
    .ia_idx  (ia_idx),
    .w_idx   (w_idx),
    .last    (last)
  );

  assign bus.o_fetch_ia_idx = ia_idx;
  assign bus.o_fetch_w_idx  = w_idx;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next        = state;
    load              = 1'b0;
    advance           = 1'b0;
    bus.o_busy        = is_busy(state);
    bus.o_layer_done  = 1'b0;
    bus.o_fetch_valid = 1'b0;
    bus.o_pe_start    = 1'b0;
    bus.o_wb_valid    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.i_layer_start) begin
          load       = 1'b1;
          state_next = zero_layer ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        bus.o_fetch_valid = 1'b1;
        if (bus.i_fetch_ready) state_next = S_WAIT_LD;
      end
      S_WAIT_LD: begin
        if (bus.i_fetch_done) state_next = S_RUN;
      end
      S_RUN: begin
        bus.o_pe_start = 1'b1;
        if (bus.i_pe_finish) state_next = S_DRAIN;
      end
      // Finish must be seen low before the next start can be issued.
      S_DRAIN: begin
        if (!bus.i_pe_finish) state_next = S_WB;
      end
      S_WB: begin
        bus.o_wb_valid = 1'b1;
        if (bus.i_wb_ready) begin
          advance    = 1'b1;
          state_next = last ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        bus.o_layer_done = 1'b1;
        state_next       = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

`ifdef PE_SCHED_PERF_EN
  logic stall;

  always_comb begin
    stall = 1'b0;
    case (state)
      S_FETCH:   stall = !bus.i_fetch_ready;
      S_WAIT_LD: stall = !bus.i_fetch_done;
      S_WB:      stall = !bus.i_wb_ready;
      default:   stall = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_perf_busy_cyc  <= '0;
      o_perf_stall_cyc <= '0;
    end else if (load) begin
      o_perf_busy_cyc  <= '0;
      o_perf_stall_cyc <= '0;
    end else begin
      if (is_busy(state) && (o_perf_busy_cyc != '1))
        o_perf_busy_cyc <= o_perf_busy_cyc + PERF_W'(1);
      if (stall && (o_perf_stall_cyc != '1))
        o_perf_stall_cyc <= o_perf_stall_cyc + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pe_tile_scheduler.sv
// Self-checking bench for pe_tile_scheduler: handshake-count model plus directed layers.
module tb_pe_tile_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pe_tile_scheduler_if bus ();

`ifdef PE_SCHED_PERF_EN
  logic [31:0] perf_busy;
  logic [31:0] perf_stall;
`endif

  pe_tile_scheduler dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
`ifdef PE_SCHED_PERF_EN
    , .o_perf_busy_cyc  (perf_busy)
    , .o_perf_stall_cyc (perf_stall)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  int cfg_fr_dly, cfg_ld_extra, cfg_pe_lat, cfg_pe_hold, cfg_wb_dly;
  bit start_req;
  int req_ia, req_w;

  int fv_cnt, wb_cnt, ld_wait, pe_cnt, hold;
  bit loading, fin, last_fin, prev_start;

  // Model: a layer is a list of pairs; each pair passes fetch, load, run, drain, wb in turn.
  bit m_active, m_done;
  int m_ia, m_w, m_total, f_cnt, l_cnt, r_cnt, d_cnt, w_cnt;
  logic [31:0] m_busy_cyc, m_stall_cyc;

  logic [15:0] obs_fetch[$];
  int n_rise, n_wbhs, n_done, fv_cycles, wbv_cycles, busy_cycles;
  int tick_no, start_tick, done_tick, cur_pair;
  bit exp_done_seen, exp_start_now;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_done = 0;
    m_ia = 0; m_w = 0; m_total = 0;
    f_cnt = 0; l_cnt = 0; r_cnt = 0; d_cnt = 0; w_cnt = 0;
    m_busy_cyc = '0; m_stall_cyc = '0;
  endtask

  task automatic resp_reset();
    fv_cnt = 0; wb_cnt = 0; ld_wait = 0; pe_cnt = 0; hold = 0;
    loading = 0; fin = 0; last_fin = 0; prev_start = 0;
    bus.i_fetch_ready = 1'b0; bus.i_fetch_done = 1'b0;
    bus.i_pe_finish = 1'b0; bus.i_wb_ready = 1'b0;
    bus.i_layer_start = 1'b0;
  endtask

  task automatic obs_clear();
    obs_fetch.delete();
    n_rise = 0; n_wbhs = 0; n_done = 0;
    fv_cycles = 0; wbv_cycles = 0; busy_cycles = 0;
    done_tick = -1;
  endtask

  task automatic tick();
    logic e_fv, e_wait, e_start, e_drain, e_wbv, e_busy, e_done;
    logic [4:0] e_vec, a_vec;
    logic [7:0] e_ia, e_w;
    logic fr, fd, wr, pf, nd;
    @(negedge clk);
    tick_no++;
    e_busy  = m_active;
    e_done  = m_done;
    e_fv    = m_active && (f_cnt == w_cnt);
    e_wait  = m_active && (f_cnt == w_cnt + 1) && (l_cnt == w_cnt);
    e_start = m_active && (l_cnt == w_cnt + 1) && (r_cnt == w_cnt);
    e_drain = m_active && (r_cnt == w_cnt + 1) && (d_cnt == w_cnt);
    e_wbv   = m_active && (d_cnt == w_cnt + 1);
    e_vec = {e_busy, e_done, e_fv, e_start, e_wbv};
    a_vec = {bus.o_busy, bus.o_layer_done, bus.o_fetch_valid, bus.o_pe_start, bus.o_wb_valid};
    chk("outputs{busy,done,fv,start,wbv}", 32'(a_vec), 32'(e_vec));
    if (e_fv || e_wbv) begin
      e_ia = 8'(w_cnt % m_ia);
      e_w  = 8'(w_cnt / m_ia);
      chk("tile_idx{ia,w}", 32'({bus.o_fetch_ia_idx, bus.o_fetch_w_idx}), 32'({e_ia, e_w}));
    end
`ifdef PE_SCHED_PERF_EN
    chk("perf_busy", perf_busy, m_busy_cyc);
    chk("perf_stall", perf_stall, m_stall_cyc);
`endif
    exp_done_seen = e_done;
    exp_start_now = e_start;
    cur_pair      = w_cnt;

    // Loader, PE and writeback partners react to what the DUT shows.
    if (bus.o_fetch_valid) begin fr = (fv_cnt >= cfg_fr_dly); fv_cnt++; end
    else begin fr = 1'b0; fv_cnt = 0; end
    fd = 1'b0;
    if (loading) begin
      if (ld_wait >= cfg_ld_extra) begin fd = 1'b1; loading = 1'b0; end
      else ld_wait++;
    end
    if (bus.o_fetch_valid && fr) begin
      loading = 1'b1;
      ld_wait = 0;
      obs_fetch.push_back({bus.o_fetch_ia_idx, bus.o_fetch_w_idx});
    end
    if (bus.o_pe_start) begin
      if (!prev_start) begin
        n_rise++;
        chk("start_vs_finish", 32'(last_fin), 32'(0));
      end
      pe_cnt++;
      if (pe_cnt >= cfg_pe_lat) fin = 1'b1;
      hold = cfg_pe_hold;
    end else begin
      pe_cnt = 0;
      if (fin) begin
        if (hold > 0) hold--;
        else fin = 1'b0;
      end
    end
    prev_start = bus.o_pe_start;
    pf = fin;
    last_fin = fin;
    if (bus.o_wb_valid) begin wr = (wb_cnt >= cfg_wb_dly); wb_cnt++; end
    else begin wr = 1'b0; wb_cnt = 0; end
    if (bus.o_wb_valid && wr) n_wbhs++;
    if (bus.o_layer_done) begin n_done++; done_tick = tick_no; end
    if (bus.o_fetch_valid) fv_cycles++;
    if (bus.o_wb_valid) wbv_cycles++;
    if (bus.o_busy) busy_cycles++;

    bus.i_fetch_ready  = fr;
    bus.i_fetch_done   = fd;
    bus.i_pe_finish    = pf;
    bus.i_wb_ready     = wr;
    bus.i_layer_start  = start_req;
    bus.i_num_ia_tiles = 8'(req_ia);
    bus.i_num_w_tiles  = 8'(req_w);

    if (!rst) begin
      nd = 1'b0;
      if (m_active) begin
        if (e_busy) m_busy_cyc = m_busy_cyc + 32'd1;
        if ((e_fv && !fr) || (e_wait && !fd) || (e_wbv && !wr)) m_stall_cyc = m_stall_cyc + 32'd1;
        if (e_fv && fr) f_cnt++;
        if (e_wait && fd) l_cnt++;
        if (e_start && pf) r_cnt++;
        if (e_drain && !pf) d_cnt++;
        if (e_wbv && wr) begin
          w_cnt++;
          if (w_cnt == m_total) begin m_active = 0; nd = 1'b1; end
        end
      end else if (!m_done && start_req) begin
        m_ia = req_ia; m_w = req_w; m_total = req_ia * req_w;
        m_busy_cyc = '0; m_stall_cyc = '0;
        f_cnt = 0; l_cnt = 0; r_cnt = 0; d_cnt = 0; w_cnt = 0;
        if (m_total == 0) nd = 1'b1;
        else m_active = 1;
      end
      m_done = nd;
    end
  endtask

  task automatic run_layer(input int ia, input int w, input bit poke);
    bit got;
    req_ia = ia; req_w = w; start_req = 1'b1;
    tick();
    start_tick = tick_no;
    start_req = 1'b0;
    got = 0;
    for (int c = 0; c < 2000 && !got; c++) begin
      // A start pulse with other counts mid-layer must be ignored.
      if (poke && c == 3) begin start_req = 1'b1; req_ia = 1; req_w = 1; end
      else start_req = 1'b0;
      tick();
      got = exp_done_seen;
    end
    start_req = 1'b0;
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL layer_timeout: got no done expected done within 2000 cycles");
    end
    tick();
  endtask

  logic [15:0] t1_list [6];
  logic [15:0] t5_list [4];

  initial begin
    bit got;
    t1_list = '{16'h0000, 16'h0100, 16'h0001, 16'h0101, 16'h0002, 16'h0102};
    t5_list = '{16'h0000, 16'h0100, 16'h0001, 16'h0101};
    rst = 1'b1;
    tick_no = 0; start_tick = 0; start_req = 0; req_ia = 0; req_w = 0;
    bus.i_num_ia_tiles = '0; bus.i_num_w_tiles = '0;
    cfg_fr_dly = 0; cfg_ld_extra = 0; cfg_pe_lat = 3; cfg_pe_hold = 0; cfg_wb_dly = 0;
    model_reset(); resp_reset(); obs_clear();
    #1;
    chk("reset_state", 32'({bus.o_busy, bus.o_layer_done, bus.o_fetch_valid, bus.o_pe_start,
                           bus.o_wb_valid, bus.o_fetch_ia_idx, bus.o_fetch_w_idx}), 32'(0));
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1) 2x3 layer, partners ready at once
    obs_clear();
    run_layer(2, 3, 0);
    chk("t1_fetch_count", 32'(obs_fetch.size()), 32'(6));
    for (int i = 0; i < 6; i++) chk("t1_fetch_order", 32'(obs_fetch[i]), 32'(t1_list[i]));
    chk("t1_start_pulses", 32'(n_rise), 32'(6));
    chk("t1_wb_count", 32'(n_wbhs), 32'(6));
    chk("t1_done_count", 32'(n_done), 32'(1));

    // 2) zero-count layer: done right after the start is sampled, nothing else moves
    obs_clear();
    run_layer(0, 5, 0);
    chk("t2_done_latency", 32'(done_tick - start_tick), 32'(1));
    chk("t2_fetch_cycles", 32'(fv_cycles), 32'(0));
    chk("t2_start_pulses", 32'(n_rise), 32'(0));
    chk("t2_busy_cycles", 32'(busy_cycles), 32'(0));
    chk("t2_done_count", 32'(n_done), 32'(1));

    // 3) fetch/wb ready held low 4 cycles, slow loader, start poked mid-layer
    obs_clear();
    cfg_fr_dly = 4; cfg_wb_dly = 4; cfg_ld_extra = 2;
    run_layer(2, 1, 1);
    chk("t3_fetch_valid_cycles", 32'(fv_cycles), 32'(10));
    chk("t3_wb_valid_cycles", 32'(wbv_cycles), 32'(10));
    chk("t3_fetch_count", 32'(obs_fetch.size()), 32'(2));
    chk("t3_second_fetch", 32'(obs_fetch[1]), 32'(16'h0100));
    chk("t3_done_count", 32'(n_done), 32'(1));
    cfg_fr_dly = 0; cfg_wb_dly = 0; cfg_ld_extra = 0;

    // 4) PE holds finish 2 extra cycles after start drops
    obs_clear();
    cfg_pe_hold = 2;
    run_layer(1, 2, 0);
    chk("t4_start_pulses", 32'(n_rise), 32'(2));
    chk("t4_wb_count", 32'(n_wbhs), 32'(2));
    cfg_pe_hold = 0;

    // 5) reset during RUN of pair (1,1), then a fresh layer restarts at (0,0)
    req_ia = 2; req_w = 2; start_req = 1'b1;
    tick();
    start_req = 1'b0;
    got = 0;
    for (int c = 0; c < 2000 && !got; c++) begin
      tick();
      got = exp_start_now && (cur_pair == 3);
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL t5_reach_run: got no RUN of pair 3 expected it within 2000 cycles");
    end
    #2 rst = 1'b1;
    #1;
    chk("t5_outputs_after_reset", 32'({bus.o_busy, bus.o_layer_done, bus.o_fetch_valid,
        bus.o_pe_start, bus.o_wb_valid, bus.o_fetch_ia_idx, bus.o_fetch_w_idx}), 32'(0));
    model_reset(); resp_reset();
    tick(); tick();
    rst = 1'b0;
    tick();
    obs_clear();
    run_layer(2, 2, 0);
    chk("t5_fetch_count", 32'(obs_fetch.size()), 32'(4));
    for (int i = 0; i < 4; i++) chk("t5_fetch_order", 32'(obs_fetch[i]), 32'(t5_list[i]));
    chk("t5_done_count", 32'(n_done), 32'(1));

`ifdef PE_SCHED_PERF_EN
    // 6) 1x1 layer, loader ready after 3 cycles: FETCH 4 + WAIT_LD 1 + RUN 3 + DRAIN 1 + WB 1
    cfg_fr_dly = 3;
    run_layer(1, 1, 0);
    tick();
    chk("t6_perf_stall", perf_stall, 32'd3);
    chk("t6_perf_busy", perf_busy, 32'd10);
    cfg_fr_dly = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
